// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared types and helpers for the data-memory arbiter.
//   - arb_state_t      : arbiter FSM state (idle / locked to one owner)
//   - LOCK_MAX_DEFAULT : default cycle limit for holding a lock
//   - idx_w()          : width of a requester index (at least 1 bit)
//   Configuration macro used by the arbiter: DMEM_ARB_RR_EN.
// ----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int LOCK_MAX_DEFAULT = 15;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// ----------------------------------------------------------------------------
// dmem_arb_pick
//   Combinational circular priority picker. Starting at index `start` and
//   wrapping modulo N, returns the first set bit of `valid`.
//   Ports:
//     valid  in  N       candidate vector
//     start  in  IDX_W   index with highest priority
//     grant  out IDX_W   selected index (0 when none)
//     any    out 1       at least one candidate present
// ----------------------------------------------------------------------------
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] grant,
    output logic             any
);

    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        any   = 1'b0;
        // Walk from the farthest offset down to offset 0 so the candidate
        // closest to `start` is the one left in grant.
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % N;
            if (valid[IDX_W'(idx)]) begin
                grant = IDX_W'(idx);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//   Shares a single-port data memory (combinational read, synchronous write)
//   between NREQ requesters. At most one transfer is accepted per cycle; the
//   response (read data or write ack) is registered and appears one cycle
//   after acceptance. A requester may lock the memory for read-modify-write
//   sequences; a lock not renewed or released within LOCK_MAX cycles is
//   force-released with a one-cycle arb_lock_timeout pulse.
//
//   Configuration macro DMEM_ARB_RR_EN:
//     defined   -> round-robin arbitration (search starts after last grant)
//     undefined -> fixed priority, lowest index wins
//
//   Ports:
//     clk, reset                 clock, asynchronous active-high reset
//     req_valid/we/lock   [NREQ] per-requester request, write, keep-lock
//     req_addr     [NREQ*AW]     per-requester byte address
//     req_wdata    [NREQ*DW]     per-requester write data
//     req_ready    [NREQ]        transfer accepted this cycle
//     rsp_valid    [NREQ]        one-cycle response pulse
//     rsp_rdata    [DW]          read data of the response
//     arb_lock_timeout           forced lock release pulse
//     data_mem_*                 memory-side ports
// ----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ-1:0]    req_lock,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               arb_lock_timeout,
    output logic               data_mem_write_enable,
    output logic [AW-1:0]      data_mem_address,
    output logic [DW-1:0]      data_mem_write_data,
    input  logic [DW-1:0]      data_mem_read_data
);

    localparam int IDX_W = idx_w(NREQ);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;

    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   owner_mask;
    logic [IDX_W-1:0]  start_idx;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_any;
    logic              accept;
    logic              lock_sel;
    logic              we_sel;
    logic              timeout;

    // While locked only the owner may compete.
    assign owner_mask = NREQ'(1) << owner_q;
    assign eligible   = (state_q == ARB_LOCKED) ? (req_valid & owner_mask) : req_valid;

`ifdef DMEM_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    assign start_idx = (ptr_q == IDX_W'(NREQ - 1)) ? '0 : ptr_q + IDX_W'(1);
    assign ptr_d     = accept ? grant_idx : ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= IDX_W'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign start_idx = '0;
`endif

    dmem_arb_pick #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid (eligible),
        .start (start_idx),
        .grant (grant_idx),
        .any   (grant_any)
    );

    // The async reset clears state at once, but the grant path is purely
    // combinational, so it is also blanked explicitly while reset is high.
    assign accept = grant_any & ~reset;

    always_comb begin
        req_ready           = '0;
        data_mem_address    = '0;
        data_mem_write_data = '0;
        we_sel              = 1'b0;
        lock_sel            = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (accept && (grant_idx == IDX_W'(i))) begin
                req_ready[i]        = 1'b1;
                data_mem_address    = req_addr[i*AW +: AW];
                data_mem_write_data = req_wdata[i*DW +: DW];
                we_sel              = req_we[i];
                lock_sel            = req_lock[i];
            end
        end
    end

    assign data_mem_write_enable = we_sel;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        timeout = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (accept && lock_sel) begin
                    state_d = ARB_LOCKED;
                    owner_d = grant_idx;
                    cnt_d   = '0;
                end
            end
            ARB_LOCKED: begin
                // Any accept here is necessarily the owner; it takes
                // precedence over an expiring counter.
                if (accept) begin
                    cnt_d = '0;
                    if (!lock_sel) begin
                        state_d = ARB_IDLE;
                    end
                end else if (cnt_q == CNT_W'(LOCK_MAX)) begin
                    state_d = ARB_IDLE;
                    cnt_d   = '0;
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign arb_lock_timeout = timeout;

    always_comb begin
        rsp_valid_d = accept ? req_ready : '0;
        rsp_rdata_d = accept ? data_mem_read_data : rsp_rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Table-driven bench for dmem_arbiter (NREQ=2). Each table row drives one
//   cycle of requests and states the expected grant and timeout; accepted
//   transfers push their expected response onto a scoreboard that is popped
//   one cycle later. Reset corner cases are hand-written sequences.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;

`ifdef DMEM_ARB_RR_EN
    localparam logic [1:0] G_ALT = 2'b10;
`else
    localparam logic [1:0] G_ALT = 2'b01;
`endif

    logic               clk;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_we;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               arb_lock_timeout;
    logic               data_mem_write_enable;
    logic [AW-1:0]      data_mem_address;
    logic [DW-1:0]      data_mem_write_data;
    logic [DW-1:0]      data_mem_read_data;

    dmem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LOCK_MAX(15)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_we                (req_we),
        .req_lock              (req_lock),
        .req_addr              (req_addr),
        .req_wdata             (req_wdata),
        .rsp_valid             (rsp_valid),
        .rsp_rdata             (rsp_rdata),
        .arb_lock_timeout      (arb_lock_timeout),
        .data_mem_write_enable (data_mem_write_enable),
        .data_mem_address      (data_mem_address),
        .data_mem_write_data   (data_mem_write_data),
        .data_mem_read_data    (data_mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory seen by the DUT, plus an independent expectation of its contents.
    logic [31:0] mem     [0:63];
    logic [31:0] exp_mem [0:63];

    assign data_mem_read_data = mem[data_mem_address[7:2]];

    always @(posedge clk) begin
        if (data_mem_write_enable) mem[data_mem_address[7:2]] <= data_mem_write_data;
    end

    typedef struct {
        string       name;
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [1:0]  lock;
        logic [31:0] a0, a1, d0, d1;
        logic [1:0]  exp_ready;
        logic        exp_to;
    } vec_t;

    typedef struct {
        logic [1:0]  oh;
        logic        is_rd;
        logic [31:0] data;
    } rsp_t;

    vec_t tbl[$];
    rsp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic vec_t mk(string nm, logic [1:0] v, logic [1:0] w, logic [1:0] l,
                                logic [31:0] a0, logic [31:0] a1, logic [31:0] d0,
                                logic [31:0] d1, logic [1:0] er, logic eto);
        vec_t r;
        r.name = nm; r.valid = v; r.we = w; r.lock = l;
        r.a0 = a0; r.a1 = a1; r.d0 = d0; r.d1 = d1;
        r.exp_ready = er; r.exp_to = eto;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called shortly after a posedge; drives one cycle and checks it.
    task automatic apply(input vec_t v);
        rsp_t        r;
        int          gi;
        logic [31:0] ea;
        logic [31:0] ewd;
        logic        ewe;
        req_valid = v.valid;
        req_we    = v.we;
        req_lock  = v.lock;
        req_addr  = {v.a1, v.a0};
        req_wdata = {v.d1, v.d0};
        #2;
        gi  = v.exp_ready[1] ? 1 : 0;
        ea  = (v.exp_ready == 2'b00) ? 32'h0 : (gi == 1 ? v.a1 : v.a0);
        ewd = (gi == 1) ? v.d1 : v.d0;
        ewe = (v.exp_ready != 2'b00) && v.we[gi];
        chk({v.name, " req_ready"}, 64'(req_ready), 64'(v.exp_ready));
        chk({v.name, " mem_addr"}, 64'(data_mem_address), 64'(ea));
        chk({v.name, " mem_we"}, 64'(data_mem_write_enable), 64'(ewe));
        chk({v.name, " timeout"}, 64'(arb_lock_timeout), 64'(v.exp_to));
        if (ewe) chk({v.name, " mem_wdata"}, 64'(data_mem_write_data), 64'(ewd));
        if (v.exp_ready != 2'b00) begin
            r.oh    = v.exp_ready;
            r.is_rd = !ewe;
            r.data  = exp_mem[ea[7:2]];
            sb.push_back(r);
            if (ewe) exp_mem[ea[7:2]] = ewd;
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk({v.name, " rsp_valid"}, 64'(rsp_valid), 64'(r.oh));
            if (r.is_rd) chk({v.name, " rsp_rdata"}, 64'(rsp_rdata), 64'(r.data));
        end else begin
            chk({v.name, " rsp_idle"}, 64'(rsp_valid), 64'h0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'h1000_0000 + 32'(i);
            exp_mem[i] = 32'h1000_0000 + 32'(i);
        end
        mem[5]     = 32'hCAFE_F00D;  exp_mem[5]  = 32'hCAFE_F00D;
        mem[6]     = 32'h6666_0006;  exp_mem[6]  = 32'h6666_0006;
        mem[12]    = 32'h0;          exp_mem[12] = 32'h0;

        // Contention (first, so arbitration starts from the reset pointer).
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk("contend", 2'b11, 2'b00, 2'b00, 32'h14, 32'h18, 0, 0,
                             (k % 2 == 0) ? 2'b01 : G_ALT, 1'b0));
        tbl.push_back(mk("idle", 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0));
        // Single read.
        tbl.push_back(mk("single_rd", 2'b01, 2'b00, 2'b00, 32'h14, 0, 0, 0, 2'b01, 1'b0));
        // Write then read back through requester 1.
        tbl.push_back(mk("wr1", 2'b10, 2'b10, 2'b00, 0, 32'h20, 0, 32'h123, 2'b10, 1'b0));
        tbl.push_back(mk("rd1", 2'b10, 2'b00, 2'b00, 0, 32'h20, 0, 0, 2'b10, 1'b0));
        tbl.push_back(mk("idle", 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0));
        // Lock held by requester 0 blocks requester 1 until released.
        tbl.push_back(mk("lock_rd", 2'b11, 2'b00, 2'b01, 32'h14, 32'h18, 0, 0, 2'b01, 1'b0));
        tbl.push_back(mk("lock_blk", 2'b10, 2'b00, 2'b00, 32'h14, 32'h18, 0, 0, 2'b00, 1'b0));
        tbl.push_back(mk("lock_wr", 2'b11, 2'b01, 2'b00, 32'h24, 32'h18, 32'hA5A5, 0, 2'b01, 1'b0));
        tbl.push_back(mk("unlocked", 2'b10, 2'b00, 2'b00, 0, 32'h18, 0, 0, 2'b10, 1'b0));
        // Timeout: owner leaves, lock expires, requester 1 then wins.
        tbl.push_back(mk("to_lock", 2'b01, 2'b00, 2'b01, 32'h14, 0, 0, 0, 2'b01, 1'b0));
        for (int k = 1; k <= 16; k++)
            tbl.push_back(mk("to_wait", 2'b10, 2'b00, 2'b00, 0, 32'h18, 0, 0, 2'b00, k == 16));
        tbl.push_back(mk("to_after", 2'b10, 2'b00, 2'b00, 0, 32'h18, 0, 0, 2'b10, 1'b0));
        // Release on the last allowed cycle beats the timeout.
        tbl.push_back(mk("rel_lock", 2'b01, 2'b00, 2'b01, 32'h14, 0, 0, 0, 2'b01, 1'b0));
        for (int k = 1; k <= 15; k++)
            tbl.push_back(mk("rel_wait", 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0));
        tbl.push_back(mk("rel_edge", 2'b01, 2'b01, 2'b00, 32'h28, 0, 32'h5555, 0, 2'b01, 1'b0));
        tbl.push_back(mk("rel_after", 2'b10, 2'b00, 2'b00, 0, 32'h28, 0, 0, 2'b10, 1'b0));

        // Reset with both requesters active.
        reset     = 1'b1;
        req_valid = 2'b11;
        req_we    = 2'b11;
        req_lock  = 2'b00;
        req_addr  = {32'h30, 32'h30};
        req_wdata = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
        #2;
        chk("rst req_ready", 64'(req_ready), 64'h0);
        chk("rst mem_we", 64'(data_mem_write_enable), 64'h0);
        chk("rst rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst rsp_rdata", 64'(rsp_rdata), 64'h0);
        chk("rst timeout", 64'(arb_lock_timeout), 64'h0);
        @(posedge clk);
        #1;
        chk("rst no write", 64'(mem[12]), 64'(exp_mem[12]));
        reset = 1'b0;

        foreach (tbl[i]) apply(tbl[i]);

        // Reset in the middle of a lock with a response pending.
        req_valid = 2'b11; req_we = 2'b00; req_lock = 2'b01;
        req_addr  = {32'h18, 32'h14};
        #2;
        chk("midrst lock ready", 64'(req_ready), 64'h1);
        @(posedge clk);
        #1;
        chk("midrst pend rsp", 64'(rsp_valid), 64'h1);
        chk("midrst pend data", 64'(rsp_rdata), 64'(exp_mem[5]));
        reset     = 1'b1;
        req_we    = 2'b11;
        req_addr  = {32'h30, 32'h30};
        req_wdata = {32'hBAD0_0001, 32'hBAD0_0000};
        #1;
        chk("midrst ready", 64'(req_ready), 64'h0);
        chk("midrst we", 64'(data_mem_write_enable), 64'h0);
        chk("midrst rsp_valid", 64'(rsp_valid), 64'h0);
        @(posedge clk);
        #1;
        chk("midrst no write", 64'(mem[12]), 64'(exp_mem[12]));
        reset = 1'b0;
        apply(mk("postrst", 2'b11, 2'b00, 2'b00, 32'h14, 32'h18, 0, 0, 2'b01, 1'b0));
        apply(mk("postrst2", 2'b10, 2'b00, 2'b00, 0, 32'h18, 0, 0, 2'b10, 1'b0));

        chk("sb drained", 64'(sb.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
